// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register file constants, address/data types and a popcount helper
package regfile_pkg;

    localparam int REG_AW    = 5;
    localparam int REG_DW    = 32;
    localparam int REG_COUNT = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;

    // Requester count is bounded at 8, so an 8-bit input covers every legal NREQ.
    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter starting its search at ptr_i
//   valid_i       : request vector
//   ptr_i         : highest-priority requester index this cycle (must be < N)
//   grant_o       : one-hot grant, zero when nothing is valid
//   grant_idx_o   : index of the granted requester
//   grant_valid_o : some requester was granted
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] grant_idx_o,
    output logic          grant_valid_o
);

    always_comb begin : search
        logic [PW-1:0] idx;
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = '0;
        // Walk requesters in order ptr, ptr+1, ... wrapping at N; first valid wins.
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!grant_valid_o && valid_i[idx]) begin
                grant_o[idx]  = 1'b1;
                grant_idx_o   = idx;
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the register file write port
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/addr/data : NREQ packed write requests (slice i at [i*W +: W])
//   req_ready           : one-hot grant, gated off by reset and wb_hold
//   wb_hold             : pipeline stall, suppresses all grants
//   wr_en/addr/data     : registered register file write port
//   conflict_cnt        : saturating count of unstalled cycles with >= 2 valid requests
//   Optional build macro: REGFILE_R0_DISCARD_EN (requests to register 0 handshake but never write)
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 wb_hold,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data,
    output logic [CNTW-1:0]      conflict_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            grant_valid;
    logic            accept;
    logic            do_write;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            contention;

    rr_arbiter #(.N(NREQ)) u_rr (
        .valid_i       (req_valid),
        .ptr_i         (rr_ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // Gating is combinational so a stall blocks the handshake in the same cycle.
    assign req_ready = (reset || wb_hold) ? '0 : grant;
    assign accept    = grant_valid && !reset && !wb_hold;
    assign sel_addr  = req_addr[int'(grant_idx)*AW +: AW];
    assign sel_data  = req_data[int'(grant_idx)*DW +: DW];

`ifdef REGFILE_R0_DISCARD_EN
    assign do_write = accept && (sel_addr != '0);
`else
    assign do_write = accept;
`endif

    assign contention = (count_ones(8'(req_valid)) >= 4'd2) && !wb_hold;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = do_write;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cnt_d     = cnt_q;
        if (accept) begin
            rr_ptr_d  = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end
        if (contention && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        wb_hold;
    logic [2:0]  req_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [15:0] conflict_cnt;

    logic [2:0]  s_ready;
    logic        s_wr_en;
    logic [4:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic [1:0]  s_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NREQ(3), .AW(5), .DW(32), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .wb_hold(wb_hold),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .conflict_cnt(conflict_cnt)
    );

    regfile_wb_arbiter #(.NREQ(3), .AW(5), .DW(32), .CNTW(2)) dut_small (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(s_ready), .wb_hold(wb_hold),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .conflict_cnt(s_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; req_valid = '0; wb_hold = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; wb_hold = 1'b0; req_valid = 3'b111;
        req_addr = {5'd3, 5'd2, 5'd1};
        req_data = {32'hC, 32'hB, 32'hA};
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready got %b exp 000", req_ready); end
            tick();
            n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
            n_vec++; if (conflict_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", conflict_cnt); end
        end
        n_vec++; if (wr_addr !== 5'd0 || wr_data !== 32'd0) begin n_err++; $display("FAIL reset_wr_port got %0d/%h exp 0/0", wr_addr, wr_data); end
        reset = 1'b0;
        #1;
        n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL reset_first_grant got %b exp 001", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_single;
        do_reset();
        req_valid = 3'b010;
        req_addr  = {5'd0, 5'd7, 5'd0};
        req_data  = {32'h0, 32'hDEADBEEF, 32'h0};
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL single_ready[%0d] got %b exp 010", c, req_ready); end
            tick();
            n_vec++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'hDEADBEEF) begin
                n_err++; $display("FAIL single_write[%0d] got %b/%0d/%h exp 1/7/deadbeef", c, wr_en, wr_addr, wr_data);
            end
        end
        req_valid = '0;
        tick();
        n_vec++; if (wr_en !== 1'b0 || wr_addr !== 5'd7 || wr_data !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL single_idle got %b/%0d/%h exp 0/7/deadbeef", wr_en, wr_addr, wr_data);
        end
        n_vec++; if (conflict_cnt !== 16'd0) begin n_err++; $display("FAIL single_cnt got %0d exp 0", conflict_cnt); end
    endtask

    task automatic test_contention;
        logic [2:0]  exp_g;
        logic [4:0]  exp_a;
        logic [31:0] exp_d;
        do_reset();
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {32'h102, 32'h101, 32'h100};
        for (int k = 0; k < 6; k++) begin
            exp_g = 3'b001 << (k % 3);
            exp_a = 5'((k % 3) + 1);
            exp_d = 32'h100 + 32'(k % 3);
            #1;
            n_vec++; if (req_ready !== exp_g) begin n_err++; $display("FAIL contention_grant[%0d] got %b exp %b", k, req_ready, exp_g); end
            tick();
            n_vec++; if (wr_en !== 1'b1 || wr_addr !== exp_a || wr_data !== exp_d) begin
                n_err++; $display("FAIL contention_write[%0d] got %b/%0d/%h exp 1/%0d/%h", k, wr_en, wr_addr, wr_data, exp_a, exp_d);
            end
        end
        n_vec++; if (conflict_cnt !== 16'd6) begin n_err++; $display("FAIL contention_cnt got %0d exp 6", conflict_cnt); end
        n_vec++; if (s_cnt !== 2'd3) begin n_err++; $display("FAIL contention_cnt_sat got %0d exp 3", s_cnt); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_same_addr;
        do_reset();
        req_valid = 3'b101;
        req_addr  = {5'd5, 5'd0, 5'd5};
        req_data  = {32'h22, 32'h0, 32'h11};
        #1;
        n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL same_addr_g0 got %b exp 001", req_ready); end
        tick();
        n_vec++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'h11) begin
            n_err++; $display("FAIL same_addr_w0 got %b/%0d/%h exp 1/5/11", wr_en, wr_addr, wr_data);
        end
        req_valid = 3'b100;
        #1;
        n_vec++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL same_addr_g2 got %b exp 100", req_ready); end
        tick();
        n_vec++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'h22) begin
            n_err++; $display("FAIL same_addr_w2 got %b/%0d/%h exp 1/5/22", wr_en, wr_addr, wr_data);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_hold_and_reset;
        do_reset();
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = {32'hC, 32'hB, 32'hA};
        tick();
        wb_hold = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL hold_ready[%0d] got %b exp 000", c, req_ready); end
            tick();
            n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL hold_wr_en[%0d] got %b exp 0", c, wr_en); end
        end
        wb_hold = 1'b0;
        #1;
        n_vec++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL hold_ptr got %b exp 010", req_ready); end
        n_vec++; if (conflict_cnt !== 16'd1) begin n_err++; $display("FAIL hold_cnt got %0d exp 1", conflict_cnt); end
        tick();
        reset = 1'b1;
        #1;
        n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL midreset_ready got %b exp 000", req_ready); end
        tick();
        n_vec++; if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0 || conflict_cnt !== 16'd0) begin
            n_err++; $display("FAIL midreset_clear got %b/%0d/%h/%0d exp 0/0/0/0", wr_en, wr_addr, wr_data, conflict_cnt);
        end
        reset = 1'b0;
        #1;
        n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL midreset_ptr got %b exp 001", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_r0;
        do_reset();
        req_valid = 3'b001;
        req_addr  = {5'd9, 5'd8, 5'd0};
        req_data  = {32'h77, 32'h66, 32'h55};
        #1;
        n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL r0_ready got %b exp 001", req_ready); end
        tick();
`ifdef REGFILE_R0_DISCARD_EN
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL r0_discard got %b exp 0", wr_en); end
`else
        n_vec++; if (wr_en !== 1'b1 || wr_addr !== 5'd0 || wr_data !== 32'h55) begin
            n_err++; $display("FAIL r0_forward got %b/%0d/%h exp 1/0/55", wr_en, wr_addr, wr_data);
        end
`endif
        req_valid = 3'b011;
        #1;
        n_vec++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL r0_ptr got %b exp 010", req_ready); end
        tick();
        n_vec++; if (wr_en !== 1'b1 || wr_addr !== 5'd8 || wr_data !== 32'h66) begin
            n_err++; $display("FAIL r0_next got %b/%0d/%h exp 1/8/66", wr_en, wr_addr, wr_data);
        end
        req_valid = '0;
        tick();
    endtask

    initial begin
        reset = 1'b1; wb_hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        tick();
        test_reset();
        test_single();
        test_contention();
        test_same_addr();
        test_hold_and_reset();
        test_r0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
